// File: rtl/fifo_status_led_ctrl_if.sv
// fifo_status_led_ctrl_if: async FIFO status inputs and LED/status outputs of fifo_status_led_ctrl
interface fifo_status_led_ctrl_if #(parameter int CNT_W = 8);
  logic pll_lock, rst_busy_i, rdata_error_i, fifo_full_i, fifo_empty_i;
  logic led_blink, led_error, led_full, led_empty;
  logic [1:0] state_o;
  logic [CNT_W-1:0] full_cnt_o;
  modport master (
    output pll_lock, rst_busy_i, rdata_error_i, fifo_full_i, fifo_empty_i,
    input led_blink, led_error, led_full, led_empty, state_o, full_cnt_o
  );
  modport slave (
    input pll_lock, rst_busy_i, rdata_error_i, fifo_full_i, fifo_empty_i,
    output led_blink, led_error, led_full, led_empty, state_o, full_cnt_o
  );
endinterface

// File: rtl/fifo_status_led_ctrl.sv
// fifo_status_led_ctrl: resynchronised FIFO health FSM driving heartbeat, error and stretched flag LEDs.
// Define FIFO_STATUS_LED_ACTIVE_LOW_EN for active-low LEDs (reset value 1).
module fifo_status_led_ctrl #(
  parameter int SYNC_STAGE = 2,
  parameter int BLINK_W    = 20,
  parameter int STRETCH_W  = 16,
  parameter int CNT_W      = 8
) (
  input logic led_clk,
  input logic sys_rst,
  fifo_status_led_ctrl_if.slave st
);
`ifdef FIFO_STATUS_LED_ACTIVE_LOW_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif
  typedef enum logic [1:0] {WAIT_LOCK, WAIT_RST, RUN, FAULT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGE-1:0][4:0] sync;
  logic lock_s, busy_s, err_s, full_s, empty_s, full_d, empty_d;
  logic full_rise, empty_rise, chg, tog;
  logic [BLINK_W-1:0] beat;
  logic [STRETCH_W-1:0] full_str, empty_str;
  logic blink_q, error_q, full_q, empty_q;
  logic [CNT_W-1:0] cnt;
  assign {lock_s, busy_s, err_s, full_s, empty_s} = sync[SYNC_STAGE-1];
  assign full_rise  = full_s & ~full_d;
  assign empty_rise = empty_s & ~empty_d;
  assign chg = state_n != state;
  assign tog = state == RUN ? &beat : state == FAULT ? &beat[BLINK_W-3:0] : 1'b0;
  always_ff @(posedge led_clk or posedge sys_rst)
    if (sys_rst) begin
      sync    <= '0;
      full_d  <= 1'b0;
      empty_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGE-2:0], {st.pll_lock, st.rst_busy_i, st.rdata_error_i, st.fifo_full_i, st.fifo_empty_i}};
      full_d  <= full_s;
      empty_d <= empty_s;
    end
  always_ff @(posedge led_clk or posedge sys_rst)
    if (sys_rst) state <= WAIT_LOCK;
    else state <= state_n;
  // error wins over lock loss, lock loss over reset-busy
  always_comb begin
    state_n = state;
    case (state)
      WAIT_LOCK: state_n = lock_s ? WAIT_RST : WAIT_LOCK;
      WAIT_RST:  state_n = !lock_s ? WAIT_LOCK : !busy_s ? RUN : WAIT_RST;
      RUN:       state_n = err_s ? FAULT : !lock_s ? WAIT_LOCK : busy_s ? WAIT_RST : RUN;
      default:   state_n = FAULT;
    endcase
  end
  always_ff @(posedge led_clk or posedge sys_rst)
    if (sys_rst) begin
      beat      <= '0;
      blink_q   <= AL;
      error_q   <= AL;
      full_str  <= '0;
      empty_str <= '0;
      full_q    <= AL;
      empty_q   <= AL;
      cnt       <= '0;
    end else begin
      beat      <= chg ? '0 : beat + 1'b1;
      blink_q   <= chg ? (state_n == WAIT_RST) ^ AL :
                   state == WAIT_LOCK ? AL : state == WAIT_RST ? ~AL : blink_q ^ tog;
      error_q   <= (state_n == FAULT) ^ AL;
      full_str  <= full_rise ? '1 : full_str - STRETCH_W'(|full_str);
      empty_str <= empty_rise ? '1 : empty_str - STRETCH_W'(|empty_str);
      full_q    <= (full_s | (|full_str)) ^ AL;
      empty_q   <= (empty_s | (|empty_str)) ^ AL;
      cnt       <= (full_rise && state == RUN && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
  assign st.led_blink  = blink_q;
  assign st.led_error  = error_q;
  assign st.led_full   = full_q;
  assign st.led_empty  = empty_q;
  assign st.state_o    = state;
  assign st.full_cnt_o = cnt;
endmodule

// File: tb/tb_fifo_status_led_ctrl.sv
// tb_fifo_status_led_ctrl: scoreboard bench; a history-based reference model predicts every cycle's outputs.
module tb_fifo_status_led_ctrl;
  localparam int SS = 2, BW = 4, SW = 3, CW = 2;
  localparam int BP = 1 << BW, FP = 1 << (BW - 2), SP = 1 << SW, CMAX = (1 << CW) - 1;
`ifdef FIFO_STATUS_LED_ACTIVE_LOW_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif
  typedef struct packed {
    logic [1:0]    st;
    logic          blink, err, full, empty;
    logic [CW-1:0] cnt;
  } exp_t;
  logic led_clk = 1'b0, sys_rst = 1'b1;
  fifo_status_led_ctrl_if #(.CNT_W(CW)) st_if ();
  fifo_status_led_ctrl #(.SYNC_STAGE(SS), .BLINK_W(BW), .STRETCH_W(SW), .CNT_W(CW)) dut (
    .led_clk(led_clk), .sys_rst(sys_rst), .st(st_if)
  );
  always #5 led_clk = ~led_clk;
  exp_t q[$];
  exp_t e, a;
  int compared = 0, mismatched = 0;
  logic [4:0] hist [0:4095];
  int st_h [0:4095];
  int n, entry, cnt_m, fault_at;
  logic lock, busy, full, empty;
  // input bit b as seen after synchronisation, after edge r
  function automatic logic sv(int b, int r);
    return r >= SS ? hist[r-SS][b] : 1'b0;
  endfunction
  function automatic logic rise(int b, int r);
    return r >= 1 && sv(b, r) && !sv(b, r - 1);
  endfunction
  function automatic logic stretched(int b, int m);
    logic on;
    on = sv(b, m - 1);
    for (int k = 2; k <= SP; k++) if (m - k >= 1 && rise(b, m - k)) on = 1'b1;
    return on;
  endfunction
  function automatic exp_t reset_exp();
    exp_t x;
    x.st = 2'd0; x.blink = AL; x.err = AL; x.full = AL; x.empty = AL; x.cnt = '0;
    return x;
  endfunction
  function automatic void model_step(int m);
    int prev, nx;
    logic l, b, er;
    exp_t x;
    prev = st_h[m-1];
    l = sv(4, m - 1); b = sv(3, m - 1); er = sv(2, m - 1);
    case (prev)
      0: nx = l ? 1 : 0;
      1: nx = !l ? 0 : !b ? 2 : 1;
      2: nx = er ? 3 : !l ? 0 : b ? 1 : 2;
      default: nx = 3;
    endcase
    if (rise(1, m - 1) && prev == 2 && cnt_m < CMAX) cnt_m++;
    st_h[m] = nx;
    if (nx != prev) entry = m;
    x.st    = 2'(nx);
    x.blink = (nx == 1 ? 1'b1 : nx == 2 ? 1'(((m - entry) / BP) % 2) :
               nx == 3 ? 1'(((m - entry) / FP) % 2) : 1'b0) ^ AL;
    x.err   = (nx == 3) ^ AL;
    x.full  = stretched(1, m) ^ AL;
    x.empty = stretched(0, m) ^ AL;
    x.cnt   = CW'(cnt_m);
    q.push_back(x);
  endfunction
  task automatic drive(input logic l, b, er, f, y);
    st_if.pll_lock = l; st_if.rst_busy_i = b; st_if.rdata_error_i = er;
    st_if.fifo_full_i = f; st_if.fifo_empty_i = y;
  endtask
  task automatic tick(input logic l, b, er, f, y);
    @(posedge led_clk);
    #1;
    n++;
    drive(l, b, er, f, y);
    hist[n] = {l, b, er, f, y};
    model_step(n);
  endtask
  task automatic do_reset(input logic l, b);
    @(posedge led_clk);
    #1;
    sys_rst = 1'b1;
    q.push_back(reset_exp());
    repeat (2) begin
      @(posedge led_clk);
      #1;
      q.push_back(reset_exp());
    end
    @(posedge led_clk);
    #1;
    sys_rst = 1'b0;
    drive(l, b, 1'b0, 1'b0, 1'b0);
    n = 0; entry = 0; cnt_m = 0; st_h[0] = 0;
    hist[0] = {l, b, 3'b000};
    q.push_back(reset_exp());
  endtask
  always @(negedge led_clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {st_if.state_o, st_if.led_blink, st_if.led_error, st_if.led_full, st_if.led_empty, st_if.full_cnt_o};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs n=%0d rst=%b: got st=%0d blink=%b err=%b full=%b empty=%b cnt=%0d, required st=%0d blink=%b err=%b full=%b empty=%b cnt=%0d",
                 n, sys_rst, a.st, a.blink, a.err, a.full, a.empty, a.cnt, e.st, e.blink, e.err, e.full, e.empty, e.cnt);
      end
    end
  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(1'b0, 1'b1);
    // bring-up, WAIT_RST full pulses, stretch/retrigger, saturation, lock loss, reset mid-stretch
    for (int c = 1; c <= 188; c++) begin
      lock  = !(c < 5 || (c >= 150 && c < 170));
      busy  = c < 20 || (c >= 40 && c < 60);
      full  = c == 45 || c == 52 || (c >= 110 && c <= 134 && (c - 110) % 6 == 0);
      empty = c == 70 || c == 90 || c == 94 || c == 185;
      tick(lock, busy, 1'b0, full, empty);
    end
    do_reset(1'b0, 1'b1);
    // fault entry, then error and lock removed: FAULT must hold
    for (int c = 1; c <= 110; c++) begin
      lock = c >= 5 && c < 60;
      busy = c < 20;
      tick(lock, busy, c >= 40 && c < 55, c == 70, c == 80);
    end
    do_reset(1'b1, 1'b0);
    fault_at = int'($urandom_range(900, 1400));
    lock = 1'b1; busy = 1'b0; full = 1'b0; empty = 1'b0;
    for (int c = 1; c <= 1500; c++) begin
      if ($urandom_range(59) == 0) lock = !lock;
      if ($urandom_range(39) == 0) busy = !busy;
      if ($urandom_range(9) == 0) full = !full;
      if ($urandom_range(7) == 0) empty = !empty;
      tick(lock, busy, c >= fault_at, full, empty);
    end
    do_reset(1'b0, 1'b0);
    repeat (2) @(negedge led_clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
